spi_req_arbiter: RTL and testbench

- Shares one spi_master byte engine between N_REQ independent requesters.
- Round-robin arbitration picks one requester at a time and drives the master's cs/wr/rd/in_data strobes.
- Waits a fixed byte time, captures read data and returns it with a one-cycle done pulse.
- Sits between the system-side agents and spi_master; it is the only driver of the master's control inputs.

---
 rtl/spi_req_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_spi_req_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one spi_master byte engine between N_REQ requesters.
// Optional macro SPI_ARB_BURST_EN adds req_last so one grant can run consecutive bytes with cs held low.
module spi_req_arbiter #(
   parameter int N_REQ       = 4,
   parameter int BYTE_CYCLES = 18,
   parameter int GAP_CYCLES  = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ-1:0]   req_rd,
   input  logic [8*N_REQ-1:0] req_wdata,
`ifdef SPI_ARB_BURST_EN
   input  logic [N_REQ-1:0]   req_last,
`endif
   output logic [N_REQ-1:0]   gnt,
   output logic [N_REQ-1:0]   done,
   output logic [7:0]         rdata,
   output logic               busy,
   output logic               m_cs,
   output logic               m_wr,
   output logic               m_rd,
   output logic [7:0]         m_in_data,
   input  logic [7:0]         m_out_data
);
   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = $clog2(BYTE_CYCLES + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, DONE, GAP} state_t;

   state_t           state, state_nxt;
   logic [PW-1:0]    ptr, ptr_nxt;
   logic [PW-1:0]    win, win_nxt;
   logic [PW-1:0]    pick, sel;
   logic             pick_vld;
   logic [N_REQ-1:0] gnt_nxt;
   logic             typ, typ_nxt;
   logic [7:0]       wdat, wdat_nxt;
   logic [7:0]       rdata_nxt;
   logic [7:0]       sel_wdat;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [GW-1:0]    gap, gap_nxt;
   logic             burst_go;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(N_REQ - 1)) ? '0 : p + 1'b1;
   endfunction

   // Scan downward so the lowest offset from ptr is the last, winning assignment.
   always_comb begin
      int idx;
      idx      = 0;
      pick_vld = 1'b0;
      pick     = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % N_REQ;
         if (req[PW'(idx)]) begin
            pick_vld = 1'b1;
            pick     = PW'(idx);
         end
      end
   end

   assign sel = (state == IDLE) ? pick : win;

   always_comb begin
      sel_wdat = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (sel == PW'(i)) sel_wdat = req_wdata[8*i +: 8];
      end
   end

`ifdef SPI_ARB_BURST_EN
   assign burst_go = req[win] & ~req_last[win];
`else
   assign burst_go = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      win_nxt   = win;
      gnt_nxt   = gnt;
      typ_nxt   = typ;
      wdat_nxt  = wdat;
      cnt_nxt   = cnt;
      gap_nxt   = gap;
      rdata_nxt = rdata;
      done      = '0;
      m_cs      = 1'b1;
      m_wr      = 1'b0;
      m_rd      = 1'b0;
      case (state)
         IDLE: begin
            if (pick_vld) begin
               gnt_nxt       = '0;
               gnt_nxt[pick] = 1'b1;
               win_nxt       = pick;
               typ_nxt       = req_rd[pick];
               wdat_nxt      = sel_wdat;
`ifndef SPI_ARB_BURST_EN
               ptr_nxt       = next_ptr(pick);
`endif
               state_nxt     = LAUNCH;
            end
         end
         LAUNCH: begin
            m_cs      = 1'b0;
            m_wr      = ~typ;
            m_rd      = typ;
            cnt_nxt   = CW'(BYTE_CYCLES - 1);
            state_nxt = WAIT;
         end
         WAIT: begin
            // rd stays up so the master keeps out_data driven until capture.
            m_cs = 1'b0;
            m_rd = typ;
            if (cnt == '0) begin
               if (typ) rdata_nxt = m_out_data;
               state_nxt = DONE;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         DONE: begin
            done = gnt;
            if (burst_go) begin
               m_cs      = 1'b0;
               typ_nxt   = req_rd[win];
               wdat_nxt  = sel_wdat;
               state_nxt = LAUNCH;
            end else begin
               gnt_nxt   = '0;
`ifdef SPI_ARB_BURST_EN
               ptr_nxt   = next_ptr(win);
`endif
               gap_nxt   = GW'(GAP_CYCLES - 1);
               state_nxt = GAP;
            end
         end
         GAP: begin
            if (gap == '0) state_nxt = IDLE;
            else           gap_nxt   = gap - 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr   <= '0;
         win   <= '0;
         gnt   <= '0;
         typ   <= 1'b0;
         wdat  <= '0;
         cnt   <= '0;
         gap   <= '0;
         rdata <= '0;
      end else begin
         ptr   <= ptr_nxt;
         win   <= win_nxt;
         gnt   <= gnt_nxt;
         typ   <= typ_nxt;
         wdat  <= wdat_nxt;
         cnt   <= cnt_nxt;
         gap   <= gap_nxt;
         rdata <= rdata_nxt;
      end
   end

   assign busy      = (state != IDLE);
   assign m_in_data = wdat;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Scoreboard bench for spi_req_arbiter: a cycle-level transaction model predicts every done pulse.
module tb_spi_req_arbiter;
   localparam int N = 4;
   localparam int B = 18;
   localparam int G = 2;

   typedef struct {
      int         idx;
      logic       rd;
      logic [7:0] wdata;
      logic [7:0] rdata;
      int         dcyc;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req, req_rd;
   logic [8*N-1:0] req_wdata;
`ifdef SPI_ARB_BURST_EN
   logic [N-1:0]   req_last;
`endif
   logic [N-1:0]   gnt, done;
   logic [7:0]     rdata, m_in_data, m_out_data;
   logic           busy, m_cs, m_wr, m_rd;

   spi_req_arbiter #(.N_REQ(N), .BYTE_CYCLES(B), .GAP_CYCLES(G)) dut (
      .clk(clk), .rst(rst), .req(req), .req_rd(req_rd), .req_wdata(req_wdata),
`ifdef SPI_ARB_BURST_EN
      .req_last(req_last),
`endif
      .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
      .m_cs(m_cs), .m_wr(m_wr), .m_rd(m_rd), .m_in_data(m_in_data),
      .m_out_data(m_out_data)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   int cyc = 0;
   exp_t exp_q[$];
   int seen[$];
   int gaps[$];

   // reference model state
   int         ptr = 0;
   int         idle_from = 0;
   int         n_grant = 0;
   int         last_arb = 0;
   int         force_out = -1;
   logic [7:0] exp_rdata = 8'h00;
   logic [N-1:0] granted = '0;
   logic [N-1:0] keep = '0;
   int         dcyc [N];

   // monitor state
   int         rd_cnt = 0, wr_cnt = 0, zero_run = 0, cs_hi = 0, last_done_cyc = 0;
   logic       win_on = 1'b0;
   logic [7:0] lw = 8'h00;
   exp_t       me;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
      end
   endtask

   task automatic push_txn(input int i);
      exp_t       e;
      logic [7:0] ob;
      ob = (force_out >= 0) ? 8'(force_out) : 8'($urandom);
      m_out_data = ob;
      e.idx   = i;
      e.rd    = req_rd[i];
      e.wdata = req_wdata[8*i +: 8];
      if (e.rd) exp_rdata = ob;
      e.rdata = exp_rdata;
      e.dcyc  = cyc + B + 2;
      granted[i] = 1'b1;
      dcyc[i]    = e.dcyc;
      idle_from  = e.dcyc + G + 1;
      exp_q.push_back(e);
   endtask

   // Evaluate what the arbiter does with the inputs driven in the current cycle.
   task automatic model_eval();
      int w;
`ifdef SPI_ARB_BURST_EN
      for (int i = 0; i < N; i++)
         if (granted[i] && cyc == dcyc[i] && req[i] && !req_last[i]) push_txn(i);
`endif
      if (cyc >= idle_from && req != '0) begin
         w = -1;
         for (int k = 0; k < N; k++)
            if (w < 0 && req[(ptr + k) % N]) w = (ptr + k) % N;
         ptr = (w + 1) % N;
         push_txn(w);
         n_grant++;
         last_arb = cyc;
      end
   endtask

   task automatic tick();
      model_eval();
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < N; i++)
         if (granted[i] && cyc == dcyc[i] + 1) begin
            granted[i] = 1'b0;
            if (!keep[i]) req[i] = 1'b0;
         end
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 200 && !(cyc >= idle_from && granted == '0); n++) tick();
      tick();
   endtask

   always @(negedge clk) begin
      if (rst) begin
         rd_cnt = 0; wr_cnt = 0; zero_run = 0;
      end else begin
         chk("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
         chk("wr_rd_excl", 32'(m_wr & m_rd), 32'd0);
         if (win_on && m_cs) cs_hi++;
         if (m_wr) begin wr_cnt++; lw = m_in_data; end
         if (m_rd) rd_cnt++;
         if (gnt == '0) zero_run++;
         else if (zero_run != 0) begin gaps.push_back(zero_run); zero_run = 0; end
         if (done != '0) begin
            if (exp_q.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
            else begin
               me = exp_q.pop_front();
               chk("done_idx", 32'(done), 32'd1 << me.idx);
               chk("done_cycle", cyc, me.dcyc);
               chk("rdata", 32'(rdata), 32'(me.rdata));
               chk("gnt_in_done", 32'(gnt), 32'(done));
               chk("rd_cycles", rd_cnt, me.rd ? B + 1 : 0);
               chk("wr_cycles", wr_cnt, me.rd ? 0 : 1);
               if (!me.rd) chk("launch_wdata", 32'(lw), 32'(me.wdata));
            end
            seen.push_back($clog2(done));
            last_done_cyc = cyc;
            rd_cnt = 0; wr_cnt = 0;
         end
      end
   end

   initial begin
      int rise;
      int exp_order [6] = '{0, 1, 3, 0, 1, 3};
      rst = 1'b1; req = '0; req_rd = '0; req_wdata = '0; m_out_data = 8'h00;
`ifdef SPI_ARB_BURST_EN
      req_last = '1;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("rst_gnt", 32'(gnt), 0);   chk("rst_done", 32'(done), 0);
      chk("rst_rdata", 32'(rdata), 0); chk("rst_busy", 32'(busy), 0);
      chk("rst_m_cs", 32'(m_cs), 1); chk("rst_m_wr", 32'(m_wr), 0);
      chk("rst_m_rd", 32'(m_rd), 0); chk("rst_m_in_data", 32'(m_in_data), 0);
      rst = 1'b0;

      // single write, uncontended latency; the req cycle counts as the first of 21
      req[0] = 1'b1; req_rd[0] = 1'b0; req_wdata[7:0] = 8'hA5; rise = cyc;
      tick();
      wait_idle();
      chk("write_latency", last_done_cyc - rise + 1, 21);
      chk("write_keeps_rdata", 32'(rdata), 32'h00);

      // single read
      req[2] = 1'b1; req_rd[2] = 1'b1; force_out = 8'h3C;
      tick();
      force_out = -1;
      wait_idle();
      chk("read_rdata", 32'(rdata), 32'h3C);

      // reset during WAIT with counter at 5
      req[2] = 1'b1; req_rd[2] = 1'b0; req_wdata[23:16] = 8'h5A;
      tick();
      for (int n = 0; n < 40 && cyc < last_arb + 14; n++) tick();
      rst = 1'b1;
      #1;
      chk("abort_m_cs", 32'(m_cs), 1); chk("abort_gnt", 32'(gnt), 0);
      chk("abort_busy", 32'(busy), 0); chk("abort_rdata", 32'(rdata), 0);
      chk("abort_done", 32'(done), 0);
      exp_q.delete(); granted = '0; req = '0; ptr = 0; exp_rdata = 8'h00; idle_from = 0;
      tick();
      rst = 1'b0;

      // contention from a freshly reset pointer
      gaps.delete(); seen.delete();
      req = 4'b1011; req_rd = '0; keep = 4'b1011;
      req_wdata = {8'h44, 8'h33, 8'h22, 8'h11};
      begin
         int n0;
         n0 = n_grant;
         for (int n = 0; n < 400 && n_grant < n0 + 6; n++) tick();
      end
      keep = '0;
      req = req & granted;
      wait_idle();
      chk("contention_count", seen.size(), 6);
      for (int i = 0; i < 6 && i < seen.size(); i++) chk("contention_order", seen[i], exp_order[i]);
      chk("contention_gap_count", (gaps.size() >= 6) ? 1 : 0, 1);
      for (int i = 1; i < 6 && i < gaps.size(); i++) chk("gnt_gap", gaps[i], G + 1);

      // request dropped two cycles into WAIT
      req[1] = 1'b1; req_rd[1] = 1'b1; force_out = 8'h5E;
      tick();
      force_out = -1;
      for (int n = 0; n < 10 && cyc < last_arb + 4; n++) tick();
      req[1] = 1'b0;
      wait_idle();
      chk("drop_rdata", 32'(rdata), 32'h5E);
      chk("drop_done_idx", seen[$], 1);

      // randomized traffic
      for (int t = 0; t < 1500; t++) begin
         for (int i = 0; i < N; i++) begin
            if (granted[i]) begin
               if ($urandom_range(0, 15) == 0) begin
                  req_rd[i] = 1'($urandom_range(0, 1));
                  req_wdata[8*i +: 8] = 8'($urandom);
               end
               if ($urandom_range(0, 63) == 0) req[i] = 1'b0;
            end else if (!req[i] && $urandom_range(0, 7) == 0) begin
               req[i] = 1'b1;
               req_rd[i] = 1'($urandom_range(0, 1));
               req_wdata[8*i +: 8] = 8'($urandom);
               keep[i] = ($urandom_range(0, 3) == 0);
            end
         end
         tick();
      end
      keep = '0;
      req = req & granted;
      wait_idle();

`ifdef SPI_ARB_BURST_EN
      // three-byte burst on requester 3
      seen.delete(); cs_hi = 0;
      req[3] = 1'b1; req_rd[3] = 1'b0; req_wdata[31:24] = 8'h11; req_last[3] = 1'b0; keep[3] = 1'b0;
      tick();
      win_on = 1'b1;
      for (int b = 0; b < 2; b++) begin
         for (int n = 0; n < 100 && cyc < dcyc[3]; n++) tick();
         req_wdata[31:24] = (b == 0) ? 8'h22 : 8'h33;
         tick();
         if (b == 1) req_last[3] = 1'b1;
      end
      for (int n = 0; n < 100 && cyc < dcyc[3]; n++) tick();
      win_on = 1'b0;
      wait_idle();
      chk("burst_cs_high_cycles", cs_hi, 0);
      chk("burst_done_count", seen.size(), 3);
      for (int i = 0; i < seen.size(); i++) chk("burst_done_idx", seen[i], 3);
`endif

      repeat (5) tick();
      chk("missing_done", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
